// File: rtl/uart_rx_deframer.sv
// ---------------------------------------------------------------------------
// uart_rx_deframer
//
// Receive-side UART deframer. Synchronizes the serial line, qualifies the
// start bit, shifts in DATA_SIZE data bits LSB first, checks an optional
// parity bit and the stop bit, and reports the result with one-cycle pulses.
// Each bit is decided by a 2-of-3 majority vote around the middle of the bit
// period.
//
// Ports
//   CLK_PAR     in   oversampling clock (PRESCALE x baud)
//   RST_PAR     in   asynchronous active-low reset
//   RX_IN       in   serial line, idle high, asynchronous to CLK_PAR
//   PAR_EN      in   frame carries a parity bit after the data
//   PAR_TYP     in   1 = odd parity, 0 = even parity
//   PRESCALE    in   oversampling ratio (8, 16 or 32)
//   P_DATA      out  last correctly received word
//   data_valid  out  one-cycle pulse, P_DATA updated
//   par_err     out  one-cycle pulse, parity mismatch in the frame just ended
//   stp_err     out  one-cycle pulse, stop bit sampled low
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | line idle, waiting for rx_s low (that cycle is start-bit edge 0)
// START  | start bit; abort back to IDLE if the mid-bit vote is high
// DATA   | shifting in DATA_SIZE data bits, LSB first
// PARITY | sampling the parity bit and holding the mismatch result
// STOP   | sampling the stop bit; flags registered at the vote edge
// ---------------------------------------------------------------------------
module uart_rx_deframer #(
    parameter int DATA_SIZE = 8
) (
    input  logic                 CLK_PAR,
    input  logic                 RST_PAR,
    input  logic                 RX_IN,
    input  logic                 PAR_EN,
    input  logic                 PAR_TYP,
    input  logic [5:0]           PRESCALE,
    output logic [DATA_SIZE-1:0] P_DATA,
    output logic                 data_valid,
    output logic                 par_err,
    output logic                 stp_err
);

    localparam int BW = $clog2(DATA_SIZE + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 state_q;
    logic [1:0]             sync_q;
    logic [5:0]             p_q;
    logic                   par_en_q;
    logic                   par_typ_q;
    logic [5:0]             edge_cnt_q;
    logic [BW-1:0]          bit_cnt_q;
    logic                   s1_q;
    logic                   s2_q;
    logic [DATA_SIZE-1:0]   shift_q;
    logic                   par_mis_q;
    logic [DATA_SIZE-1:0]   p_data_q;
    logic                   data_valid_q;
    logic                   par_err_q;
    logic                   stp_err_q;

    logic                   rx_s;
    logic [5:0]             half;
    logic                   at_s1;
    logic                   at_s2;
    logic                   at_vote;
    logic                   at_last;
    logic                   vote;
    logic                   par_exp;
    logic [DATA_SIZE-1:0]   shift_d;

    assign rx_s    = sync_q[1];
    assign half    = {1'b0, p_q[5:1]};
    assign at_s1   = (edge_cnt_q == half - 6'd1);
    assign at_s2   = (edge_cnt_q == half);
    assign at_vote = (edge_cnt_q == half + 6'd1);
    assign at_last = (edge_cnt_q == p_q - 6'd1);

    // The third vote sample is the live synchronized line at edge P/2+1.
    assign vote    = (s1_q & s2_q) | (s1_q & rx_s) | (s2_q & rx_s);
    assign shift_d = {vote, shift_q[DATA_SIZE-1:1]};
    assign par_exp = (^shift_q) ^ par_typ_q;

    always_ff @(posedge CLK_PAR or negedge RST_PAR) begin
        if (!RST_PAR) begin
            state_q      <= S_IDLE;
            sync_q       <= 2'b11;
            p_q          <= 6'd0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            edge_cnt_q   <= 6'd0;
            bit_cnt_q    <= '0;
            s1_q         <= 1'b1;
            s2_q         <= 1'b1;
            shift_q      <= '0;
            par_mis_q    <= 1'b0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], RX_IN};
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;

            // Common bit-period timing for every state except IDLE; the
            // state branches below override the counter where they exit.
            if (state_q != S_IDLE) begin
                edge_cnt_q <= at_last ? 6'd0 : edge_cnt_q + 6'd1;
                if (at_s1) s1_q <= rx_s;
                if (at_s2) s2_q <= rx_s;
            end

            case (state_q)
                S_IDLE: begin
                    edge_cnt_q <= 6'd0;
                    bit_cnt_q  <= '0;
                    if (!rx_s) begin
                        // This cycle is edge 0, so the next one is edge 1.
                        state_q    <= S_START;
                        edge_cnt_q <= 6'd1;
                        p_q        <= PRESCALE;
                        par_en_q   <= PAR_EN;
                        par_typ_q  <= PAR_TYP;
                        par_mis_q  <= 1'b0;
                    end
                end

                S_START: begin
                    if (at_vote && vote) begin
                        state_q    <= S_IDLE;
                        edge_cnt_q <= 6'd0;
                    end else if (at_last) begin
                        state_q <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (at_vote) shift_q <= shift_d;
                    if (at_last) begin
                        if (bit_cnt_q == BW'(DATA_SIZE - 1)) begin
                            bit_cnt_q <= '0;
                            state_q   <= par_en_q ? S_PARITY : S_STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end

                S_PARITY: begin
                    if (at_vote) par_mis_q <= (vote != par_exp);
                    if (at_last) state_q <= S_STOP;
                end

                S_STOP: begin
                    // Leaving mid-stop-bit lets a back-to-back start edge
                    // be seen on time.
                    if (at_vote) begin
                        stp_err_q  <= ~vote;
                        par_err_q  <= par_mis_q;
                        if (vote && !par_mis_q) begin
                            data_valid_q <= 1'b1;
                            p_data_q     <= shift_q;
                        end
                        state_q    <= S_IDLE;
                        edge_cnt_q <= 6'd0;
                    end
                end

                default: begin
                    state_q    <= S_IDLE;
                    edge_cnt_q <= 6'd0;
                end
            endcase
        end
    end

    assign P_DATA     = p_data_q;
    assign data_valid = data_valid_q;
    assign par_err    = par_err_q;
    assign stp_err    = stp_err_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
module tb_uart_rx_deframer;

    logic       CLK_PAR  = 1'b0;
    logic       RST_PAR  = 1'b0;
    logic       RX_IN    = 1'b1;
    logic       PAR_EN   = 1'b0;
    logic       PAR_TYP  = 1'b0;
    logic [5:0] PRESCALE = 6'd8;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;

    uart_rx_deframer #(.DATA_SIZE(8)) dut (
        .CLK_PAR    (CLK_PAR),
        .RST_PAR    (RST_PAR),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .PRESCALE   (PRESCALE),
        .P_DATA     (P_DATA),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err)
    );

    always #5 CLK_PAR = ~CLK_PAR;

    int cyc = 0;
    always @(posedge CLK_PAR) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        int         p;
        bit         pe;
        bit         typ;
        logic [7:0] data;
        bit         bad_par;
        bit         stop;
        int         glitch_bit;   // frame bit index (0 = start) to glitch at P/2, -1 none
        int         gap;          // idle-high cycles before the start bit
    } vec_t;

    typedef struct {
        int         cyc;
        bit         dv;
        bit         pe;
        bit         se;
        logic [7:0] data;
    } exp_t;

    exp_t       sbq[$];
    exp_t       e;
    logic [7:0] last_good = 8'h00;
    vec_t       vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge CLK_PAR);
        #1;
    endtask

    // Drives one frame; abort >= 0 stops after that many cycles and records
    // no expectation for the frame.
    task automatic send_frame(input vec_t v, input int abort);
        logic bits[12];
        int   nb;
        int   t0;
        int   n;
        exp_t x;
        bit   perr;
        RX_IN = 1'b1;
        repeat (v.gap) tick();
        PRESCALE = v.p[5:0];
        PAR_EN   = v.pe;
        PAR_TYP  = v.typ;
        nb = 0;
        bits[nb] = 1'b0; nb++;
        for (int i = 0; i < 8; i++) begin
            bits[nb] = v.data[i]; nb++;
        end
        if (v.pe) begin
            bits[nb] = (^v.data) ^ v.typ ^ v.bad_par; nb++;
        end
        bits[nb] = v.stop; nb++;
        t0 = cyc;
        if (abort < 0) begin
            perr   = v.pe && v.bad_par;
            x.cyc  = t0 + 2 + (9 + int'(v.pe)) * v.p + v.p / 2 + 2;
            x.pe   = perr;
            x.se   = !v.stop;
            x.dv   = !perr && v.stop;
            x.data = v.data;
            sbq.push_back(x);
        end
        n = 0;
        for (int b = 0; b < nb; b++) begin
            for (int k = 0; k < v.p; k++) begin
                if (abort >= 0 && n == abort) return;
                RX_IN = bits[b] ^ ((v.glitch_bit == b) && (k == v.p / 2));
                tick();
                n++;
            end
        end
        RX_IN = 1'b1;
    endtask

    // Scoreboard consumer and P_DATA stability check.
    always @(negedge CLK_PAR) begin
        if (data_valid || par_err || stp_err) begin
            if (sbq.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_flag: dv=%0b pe=%0b se=%0b at cycle %0d, none expected",
                         data_valid, par_err, stp_err, cyc);
            end else begin
                e = sbq.pop_front();
                check("flag_cycle", cyc, e.cyc);
                check("data_valid", data_valid, e.dv);
                check("par_err", par_err, e.pe);
                check("stp_err", stp_err, e.se);
                check("p_data", P_DATA, e.dv ? e.data : last_good);
                if (e.dv) last_good = e.data;
            end
        end else begin
            check("p_data_stable", P_DATA, last_good);
        end
    end

    initial begin
        vec_t h;
        //            p   pe typ data   badp stop glitch gap
        vecs[0] = '{  8, 1, 0, 8'hA5, 0,   1,   -1,    20 };
        vecs[1] = '{ 16, 1, 1, 8'h3C, 1,   1,   -1,    20 };
        vecs[2] = '{  8, 0, 0, 8'h5A, 0,   0,   -1,    20 };
        vecs[3] = '{ 16, 0, 0, 8'h00, 0,   1,   -1,    40 };
        vecs[4] = '{ 16, 0, 0, 8'hFF, 0,   1,   -1,     0 };
        vecs[5] = '{  8, 1, 1, 8'h12, 0,   1,    4,    20 };
        vecs[6] = '{ 32, 0, 0, 8'hC3, 0,   1,    9,    20 };
        vecs[7] = '{ 16, 1, 0, 8'h01, 0,   0,   -1,    20 };
        vecs[8] = '{  8, 1, 0, 8'h07, 1,   0,   -1,    40 };

        RST_PAR = 1'b0;
        repeat (3) tick();
        check("rst_p_data", P_DATA, 8'h00);
        check("rst_data_valid", data_valid, 1'b0);
        check("rst_par_err", par_err, 1'b0);
        check("rst_stp_err", stp_err, 1'b0);
        RST_PAR = 1'b1;
        repeat (5) tick();

        for (int i = 0; i < 9; i++) send_frame(vecs[i], -1);

        // Start-bit glitch: 3 low cycles, then a valid frame.
        repeat (40) tick();
        PRESCALE = 6'd16;
        PAR_EN   = 1'b0;
        RX_IN    = 1'b0;
        repeat (3) tick();
        RX_IN    = 1'b1;
        repeat (60) tick();
        h = '{ 16, 0, 0, 8'h81, 0, 1, -1, 0 };
        send_frame(h, -1);
        repeat (40) tick();

        // Reset in the middle of data bit 4 at P=32.
        h = '{ 32, 0, 0, 8'h3C, 0, 1, -1, 10 };
        send_frame(h, 5 * 32 + 16);
        RST_PAR = 1'b0;
        last_good = 8'h00;
        #1;
        check("midrst_p_data", P_DATA, 8'h00);
        check("midrst_data_valid", data_valid, 1'b0);
        check("midrst_par_err", par_err, 1'b0);
        check("midrst_stp_err", stp_err, 1'b0);
        RX_IN = 1'b1;
        repeat (3) tick();
        RST_PAR = 1'b1;
        h = '{ 32, 0, 0, 8'h0F, 0, 1, -1, 10 };
        send_frame(h, -1);
        repeat (100) tick();

        check("scoreboard_empty", sbq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
